// File: rtl/fwd_sel_controller_if.sv
// EX operand-forwarding control bundle: ID-stage fields in,
// load-use stall and operand mux selects out.
interface fwd_sel_controller_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  flush;
  logic                  hold;
  logic                  stall;
  logic [1:0]            forward_a;
  logic [1:0]            forward_b;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_use_rs1, id_use_rs2,
    output id_rd, id_regwrite, id_memread,
    output flush, hold,
    input  stall, forward_a, forward_b
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_use_rs1, id_use_rs2,
    input  id_rd, id_regwrite, id_memread,
    input  flush, hold,
    output stall, forward_a, forward_b
  );
endinterface

// File: rtl/fwd_sel_controller.sv
// Forwarding-select and load-use stall controller for the EX stage.
// Optional saturating stall counter enabled by FWD_STALL_CNT_EN.
module fwd_sel_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input logic                 clk,
  input logic                 reset,
  fwd_sel_controller_if.slave bus
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]    stall_count
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be positive");
  end

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
    logic                  ld;
  } ent_t;

  ent_t e1, e2, e3;
  ent_t id_ent;

  logic [1:0] fa_q, fb_q;
  logic [1:0] fa_nxt, fb_nxt;
  logic       a1, a2, b1, b2;
  logic       hz;

  function automatic logic hit(
    input ent_t                  e,
    input logic [REG_ADDR_W-1:0] src
  );
    return e.valid & e.wr & (e.rd != '0) & (e.rd == src);
  endfunction

  // Bubbles carry all-zero fields so stale tags never linger.
  always_comb begin
    id_ent = '0;
    if (bus.id_valid) begin
      id_ent.valid = 1'b1;
      id_ent.rd    = bus.id_rd;
      id_ent.wr    = bus.id_regwrite;
      id_ent.ld    = bus.id_memread;
    end
  end

  always_comb begin
    a1 = bus.id_valid & bus.id_use_rs1 & hit(e1, bus.id_rs1);
    a2 = bus.id_valid & bus.id_use_rs1 & ~a1
       & hit(e2, bus.id_rs1);
    b1 = bus.id_valid & bus.id_use_rs2 & hit(e1, bus.id_rs2);
    b2 = bus.id_valid & bus.id_use_rs2 & ~b1
       & hit(e2, bus.id_rs2);
    hz = e1.ld & (a1 | b1) & ~bus.hold & ~bus.flush;
  end

  always_comb begin
    fa_nxt = 2'b00;
    unique case (1'b1)
      a1:      fa_nxt = 2'b10;
      a2:      fa_nxt = 2'b01;
      default: fa_nxt = 2'b00;
    endcase
  end

  always_comb begin
    fb_nxt = 2'b00;
    unique case (1'b1)
      b1:      fb_nxt = 2'b10;
      b2:      fb_nxt = 2'b01;
      default: fb_nxt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e1   <= '0;
      e2   <= '0;
      e3   <= '0;
      fa_q <= 2'b00;
      fb_q <= 2'b00;
    end else if (bus.flush || (!bus.hold && hz)) begin
      e3   <= e2;
      e2   <= e1;
      e1   <= '0;
      fa_q <= 2'b00;
      fb_q <= 2'b00;
    end else if (!bus.hold) begin
      e3   <= e2;
      e2   <= e1;
      e1   <= id_ent;
      fa_q <= fa_nxt;
      fb_q <= fb_nxt;
    end
  end

  // MEM/WB entry is tracked for visibility; it never sources a select.
  always_comb begin
    assert (e3.valid || e3 == '0);
  end

  assign bus.stall     = hz;
  assign bus.forward_a = fa_q;
  assign bus.forward_b = fb_q;

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (hz && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_fwd_sel_controller.sv
// Bench for fwd_sel_controller: directed pipeline scenarios plus
// randomized traffic against an instruction-history model.
module tb_fwd_sel_controller;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fwd_sel_controller_if #(.REG_ADDR_W(AW)) bus();
`ifdef FWD_STALL_CNT_EN
  logic [CW-1:0] stall_count;
`endif

  fwd_sel_controller #(
    .REG_ADDR_W(AW),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  int nchk = 0;
  int nerr = 0;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: the last two instructions that entered EX, youngest first.
  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic          wr;
    logic          ld;
  } instr_t;

  instr_t hist0 = '0;
  instr_t hist1 = '0;
  logic [1:0] mfa = 2'b00;
  logic [1:0] mfb = 2'b00;
  int mcnt = 0;

  function automatic logic prod(input instr_t r, input logic [AW-1:0] s);
    return r.v && r.wr && r.rd != 0 && r.rd == s;
  endfunction

  function automatic logic exp_stall();
    if (!bus.id_valid || bus.hold || bus.flush || !hist0.ld)
      return 1'b0;
    return (bus.id_use_rs1 && prod(hist0, bus.id_rs1)) ||
           (bus.id_use_rs2 && prod(hist0, bus.id_rs2));
  endfunction

  function automatic logic [1:0] sel(input logic u,
                                     input logic [AW-1:0] s);
    if (!(bus.id_valid && u)) return 2'b00;
    if (prod(hist0, s)) return 2'b10;
    if (prod(hist1, s)) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist0 <= '0;
      hist1 <= '0;
      mfa   <= 2'b00;
      mfb   <= 2'b00;
      mcnt  <= 0;
    end else if (bus.flush || (!bus.hold && exp_stall())) begin
      hist1 <= hist0;
      hist0 <= '0;
      mfa   <= 2'b00;
      mfb   <= 2'b00;
      if (!bus.flush && mcnt < CMAX) mcnt <= mcnt + 1;
    end else if (!bus.hold) begin
      hist1 <= hist0;
      hist0 <= bus.id_valid ?
        instr_t'{v: 1'b1, rd: bus.id_rd,
                 wr: bus.id_regwrite, ld: bus.id_memread} : '0;
      mfa   <= sel(bus.id_use_rs1, bus.id_rs1);
      mfb   <= sel(bus.id_use_rs2, bus.id_rs2);
    end
  end

  always @(negedge clk) begin
    check("stall", 32'(bus.stall), 32'(exp_stall()));
    check("forward_a", 32'(bus.forward_a), 32'(mfa));
    check("forward_b", 32'(bus.forward_b), 32'(mfb));
`ifdef FWD_STALL_CNT_EN
    check("stall_count", 32'(stall_count), 32'(mcnt));
`endif
  end

  task automatic drive(
    input logic          v,
    input logic [AW-1:0] rs1, input logic u1,
    input logic [AW-1:0] rs2, input logic u2,
    input logic [AW-1:0] rd,
    input logic wr, input logic ld
  );
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_use_rs1  = u1;
    bus.id_rs2      = rs2;
    bus.id_use_rs2  = u2;
    bus.id_rd       = rd;
    bus.id_regwrite = wr;
    bus.id_memread  = ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    nop();
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    #2;
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_fa", 32'(bus.forward_a), 0);
    check("rst_fb", 32'(bus.forward_b), 0);
    step();
    reset = 1'b1;

    // distance-1 RAW
    drive(1, 1, 1, 2, 1, 5, 1, 0); step();
    drive(1, 5, 1, 3, 1, 6, 1, 0);
    #1 check("d1_stall", 32'(bus.stall), 0);
    step();
    check("d1_fa", 32'(bus.forward_a), 32'h2);
    nop(); step();

    // distance-2 RAW
    drive(1, 1, 1, 2, 1, 5, 1, 0); step();
    nop(); step();
    drive(1, 0, 0, 5, 1, 0, 0, 0); step();
    check("d2_fb", 32'(bus.forward_b), 32'h1);

    // double producer
    drive(1, 1, 1, 2, 1, 5, 1, 0); step();
    drive(1, 3, 1, 4, 1, 5, 1, 0); step();
    drive(1, 5, 1, 0, 0, 8, 1, 0); step();
    check("dbl_fa", 32'(bus.forward_a), 32'h2);
    nop(); step(); step();

    // load-use
`ifdef FWD_STALL_CNT_EN
    check("cnt0", 32'(stall_count), 0);
`endif
    drive(1, 1, 1, 0, 0, 7, 1, 1); step();
    drive(1, 7, 1, 2, 1, 9, 1, 0);
    #1 check("lu_stall", 32'(bus.stall), 1);
    step();
    check("lu_bub_fa", 32'(bus.forward_a), 0);
    check("lu_stall_off", 32'(bus.stall), 0);
`ifdef FWD_STALL_CNT_EN
    check("cnt1", 32'(stall_count), 1);
`endif
    step();
    check("lu_fa", 32'(bus.forward_a), 32'h1);
    nop(); step(); step();

    // x0 destination
    drive(1, 1, 1, 0, 0, 0, 1, 0); step();
    drive(1, 0, 1, 0, 1, 3, 1, 0);
    #1 check("x0_stall", 32'(bus.stall), 0);
    step();
    check("x0_fa", 32'(bus.forward_a), 0);
    check("x0_fb", 32'(bus.forward_b), 0);
    drive(1, 1, 1, 0, 0, 0, 1, 1); step();
    drive(1, 0, 1, 0, 0, 4, 1, 0);
    #1 check("ldx0_stall", 32'(bus.stall), 0);
    step();
    nop(); step(); step();

    // flush during load-use hazard
    drive(1, 1, 1, 0, 0, 7, 1, 1); step();
    drive(1, 7, 1, 0, 0, 9, 1, 0);
    bus.flush = 1'b1;
    #1 check("fl_stall", 32'(bus.stall), 0);
    step();
    bus.flush = 1'b0;
    check("fl_fa", 32'(bus.forward_a), 0);
    #1 check("fl_e1_empty", 32'(bus.stall), 0);
    step();
    check("fl_after_fa", 32'(bus.forward_a), 32'h1);
    nop(); step(); step();

    // hold freezes selects
    drive(1, 1, 1, 0, 0, 9, 1, 0); step();
    drive(1, 9, 1, 0, 0, 0, 0, 0); step();
    check("hd_pre_fa", 32'(bus.forward_a), 32'h2);
    bus.hold = 1'b1;
    drive(1, 0, 0, 9, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hd_fa", 32'(bus.forward_a), 32'h2);
      check("hd_fb", 32'(bus.forward_b), 0);
    end
`ifdef FWD_STALL_CNT_EN
    check("hd_cnt", 32'(stall_count), 1);
`endif
    bus.hold = 1'b0;
    step();
    check("hd_res_fb", 32'(bus.forward_b), 32'h1);
    check("hd_res_fa", 32'(bus.forward_a), 0);
    nop(); step(); step();

    // reset with a hazard pending
    drive(1, 1, 1, 0, 0, 3, 1, 0); step();
    drive(1, 3, 1, 0, 0, 7, 1, 1); step();
    drive(1, 7, 1, 0, 0, 8, 1, 0);
    #1 check("rm_stall", 32'(bus.stall), 1);
    check("rm_fa_pre", 32'(bus.forward_a), 32'h2);
    reset = 1'b0;
    #1 check("rm_stall0", 32'(bus.stall), 0);
    check("rm_fa0", 32'(bus.forward_a), 0);
    check("rm_fb0", 32'(bus.forward_b), 0);
    step();
    reset = 1'b1;
    drive(1, 1, 1, 2, 1, 5, 1, 0); step();
    drive(1, 5, 1, 0, 0, 6, 1, 0); step();
    check("rm_after_fa", 32'(bus.forward_a), 32'h2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 4) != 0,
            AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) < 3);
      bus.flush = ($urandom_range(0, 19) == 0);
      bus.hold  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/fwd_sel_controller.md
# fwd_sel_controller

Sequencing controller for the 64-bit ALU operand 3:1 muxes in the EX stage. It tracks destination-register tags of in-flight instructions through internal ID/EX, EX/MEM and MEM/WB scoreboard entries. It drives the two mux select lines (`forward_a`, `forward_b`) and raises a load-use stall toward the fetch/decode stages. An optional saturating counter records stall cycles for performance analysis.

## Interface
- `REG_ADDR_W`, 5, register-index width.
- `CNT_W`, 32, stall-counter width; used only with `FWD_STALL_CNT_EN`.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  instruction in ID is real; 0 means bubble.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W  source indices of the ID instruction.
- `id_use_rs1`, `id_use_rs2`  in  1  ID instruction reads rs1 / rs2.
- `id_rd`  in  REG_ADDR_W  destination index of the ID instruction.
- `id_regwrite`  in  1  ID instruction writes `id_rd`.
- `id_memread`  in  1  ID instruction is a load.
- `flush`  in  1  taken branch or jump; kill the instruction entering EX.
- `hold`  in  1  global pipeline freeze, e.g. memory busy.
- `stall`  out  1  load-use hazard; ID and IF must hold.
- `forward_a`, `forward_b`  out  2  EX operand mux selects. 00 = register file, 01 = MEM/WB result, 10 = EX/MEM result.
- `stall_count`  out  CNT_W  stall cycles counted; present only with `FWD_STALL_CNT_EN`.

## Operation
- Scoreboard: three entries, E1 (ID/EX), E2 (EX/MEM) and E3 (MEM/WB). Each entry holds {valid, rd, regwrite, memread}.
- Producer match rule: entry valid, regwrite = 1, rd ≠ 0 and rd equals the source index. x0 never matches.
- Stall, combinational:
  - `stall` = `id_valid` & E1.valid & E1.memread & E1.regwrite & E1.rd ≠ 0 & ((`id_use_rs1` & E1.rd == `id_rs1`) | (`id_use_rs2` & E1.rd == `id_rs2`)).
  - `stall` is forced to 0 while `hold` or `flush` = 1.
- Per-edge update, highest priority first:
  1. reset: all entries invalid, selects 00, counter 0.
  2. flush: E3←E2, E2←E1, E1←invalid, `forward_a`/`forward_b`←00.
  3. hold: all entries and selects keep their values.
  4. stall: E3←E2, E2←E1, E1←invalid (bubble), selects←00.
  5. normal: E3←E2, E2←E1, E1←ID fields (valid = `id_valid`), selects←computed.
- Select computation for the instruction entering EX, per source operand independently:
  - If `id_use_rsX` and E1 matches (E1 becomes EX/MEM next cycle) → 10.
  - Else if `id_use_rsX` and E2 matches (E2 becomes MEM/WB) → 01.
  - Else → 00.
  - E1 has priority over E2 (youngest producer wins).
  - A load in E1 matching a source is impossible in the normal branch because it stalls. After the bubble the load sits in E2, giving 01.
  - Encoding 11 is never driven.
- With `id_valid` = 0, the selects are 00.

## Timing
- `stall`: zero-latency combinational from the ID inputs and E1. It is asserted for exactly 1 cycle per load-use hazard unless `hold` intervenes.
- `forward_a`/`forward_b`: registered. They are valid throughout the cycle the instruction occupies EX, which is 1 cycle after it was presented in ID.
- Reset values: `stall` = 0 (all entries invalid), `forward_a` = `forward_b` = 00, `stall_count` = 0.
- Reset mid-operation: asynchronous clear on the falling edge of `reset`. Outputs are at reset values in the same cycle. The first ID instruction after release sees an empty scoreboard.
- `flush` and `hold` together: flush wins, so the entries shift and E1 is cleared.

## Configuration
- Macro `FWD_STALL_CNT_EN`:
  - Defined: `stall_count` port exists. It increments on every clock edge where `stall` = 1 and `hold` = 0. It saturates at 2^CNT_W−1 (no wrap) and clears only on reset.
  - Undefined: the port and counter logic are absent. All other behaviour is identical.

## Test plan
- Distance-1 RAW: `add x5` then `sub` using rs1 = x5 in consecutive cycles → `forward_a` = 10 during the sub EX cycle, `stall` = 0.
- Distance-2 RAW: `add x5`, `nop`, then rs2 = x5 → `forward_b` = 01. Double producer (x5 written at distance 1 and 2) → 10.
- Load-use: `ld x7` then `add` using rs1 = x7 → `stall` = 1 for exactly one cycle, selects 00 on the bubble, then `forward_a` = 01 on the add EX cycle. `stall_count` 0→1 when enabled.
- x0 destination: `addi x0` then a reader of x0 → `forward_a` = `forward_b` = 00. An `ld x0` followed by a reader → `stall` = 0.
- Flush or hold: flush coincident with a load-use hazard → `stall` = 0, E1 invalid, selects 00. `hold` for 3 cycles → selects and `stall_count` unchanged, then forwarding resumes correctly.
- Reset asserted with a load in E1 and a hazard pending → `stall` drops to 0 immediately, selects 00. After release, a dependent pair forwards 10.
